apu_frame_sequencer: RTL and testbench
======================================

# apu_frame_sequencer

Frame-sequencer and register-write controller for the APU pulse channels. It owns the host-visible register file for two pulse channels (four 8-bit registers each) and generates the quarter-frame and half-frame strobes that drive each pulse channel's envelope, length and sweep units. It sits between the host write port and two pulse channel instances, all in the `apu_clk` domain.

## Interface

Parameters:
- `STEP_CYCLES`, default 3729: `apu_clk` cycles per sequencer step; legal range 2..65535.

Ports:
- `apu_clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  host write request.
- `wr_ready`  out  1  controller accepts the write this cycle.
- `wr_addr`  in  4  address: 0–3 selects pulse 1 reg_0..reg_3; 4–7 selects pulse 2 reg_0..reg_3; 8 selects frame control; 9–15 are ignored.
- `wr_data`  in  8  write data.
- `irq_ack`  in  1  clears `frame_irq`.
- `p1_reg_0`..`p1_reg_3`  out  8 each  pulse 1 register file.
- `p2_reg_0`..`p2_reg_3`  out  8 each  pulse 2 register file.
- `qtr_clk`  out  1  quarter-frame strobe, one cycle wide.
- `hlf_clk`  out  1  half-frame strobe, one cycle wide.
- `frame_irq`  out  1  sticky frame interrupt.

## Operation

- Register file:
  - A write is accepted when `wr_valid && wr_ready`.
  - Addresses 0–7 update the selected output register on that edge.
  - Addresses 9–15 are accepted and discarded.
- Frame control (address 8):
  - `wr_data[7]` selects the mode: 0 = 4-step, 1 = 5-step.
  - `wr_data[6]` is the IRQ inhibit.
  - An accepted write clears the prescaler and step index and enters the RELOAD state for one cycle.
- States:
  - IDLE/RUN: normal counting.
  - RELOAD: one cycle.
    - `wr_ready` is 0 and the prescaler is held.
    - In 5-step mode, `qtr_clk` and `hlf_clk` are both pulsed in this cycle.
    - Returns to RUN.
- Prescaler:
  - Counts 0..`STEP_CYCLES`-1. It is 16 bits wide and zero-extended from the parameter.
  - When it reaches `STEP_CYCLES`-1 it wraps to 0, fires the current step, and advances the step index.
- Step actions in 4-step mode (index wraps 3→0):
  - Steps 0 and 2: `qtr_clk`.
  - Steps 1 and 3: `qtr_clk` and `hlf_clk`.
  - Step 3 also sets the IRQ flag when inhibit = 0.
- Step actions in 5-step mode (index wraps 4→0):
  - Steps 0 and 2: `qtr_clk`.
  - Steps 1 and 4: `qtr_clk` and `hlf_clk`.
  - Step 3: no strobe.
  - The IRQ flag is never set in this mode.
- `wr_ready` is 1 in every state except RELOAD.

## Timing

- Reset values:
  - All `p*_reg_*` are 0x00.
  - `qtr_clk`, `hlf_clk` and `frame_irq` are 0.
  - `wr_ready` is 1.
  - Mode is 4-step, inhibit is 0, prescaler is 0, step index is 0.
- Write latency: a register output shows new data in the cycle after the accepting edge.
- Strobes are registered. A strobe is high for exactly the one cycle after the prescaler-wrap edge.
- The first strobe after reset or a control write arrives `STEP_CYCLES` cycles after the prescaler restarts.
- Simultaneous events:
  - A control write on the same edge as a prescaler wrap takes priority: the step is not fired and the counters clear.
  - IRQ set and `irq_ack` on the same edge: set wins.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). No strobe is emitted on release.

## Configuration

- Macro: `APU_FRAME_IRQ_EN`.
- When defined:
  - `frame_irq` behaves as described in Operation.
  - It is cleared on the edge after `irq_ack` = 1.
  - It is also cleared by any control write with `wr_data[6]` = 1.
- When undefined:
  - `frame_irq` is tied to 0.
  - `wr_data[6]` is ignored.
  - `irq_ack` is unused.
  - No IRQ flop exists.

## Test plan

All scenarios use `STEP_CYCLES` = 4.

- Reset → all registers are 0x00, strobes are 0, and `wr_ready` = 1. Writing addr 5 with 0xA7 → `p2_reg_1` = 0xA7 on the next cycle and every other register stays 0x00.
- Free-running 4-step mode for 32 cycles → `qtr_clk` pulses every 4 cycles (8 pulses). `hlf_clk` pulses on the 2nd, 4th, 6th and 8th `qtr_clk` pulse. With the macro defined, `frame_irq` rises with the 4th pulse.
- Write 0x80 to addr 8 → `wr_ready` = 0 for one cycle, and `qtr_clk` and `hlf_clk` both pulse in that RELOAD cycle. Over the following 20 cycles the pattern is q, q+h, q, none, q+h.
- Control write issued on the same edge as a prescaler wrap → no strobe fires, and the next strobe arrives 4 cycles after RELOAD ends.
- With `frame_irq` = 1: pulse `irq_ack` → `frame_irq` = 0 on the next cycle. Assert `irq_ack` on the step-3 edge → `frame_irq` stays 1. Write 0x40 to addr 8 → `frame_irq` is cleared and stays 0 through 40 cycles.
- Assert `rst` mid-step with registers loaded → outputs are 0 immediately. After release, the first `qtr_clk` arrives exactly 4 cycles later.

Source files
------------

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: pulse-channel register file plus quarter/half-frame strobe generator.
// Define APU_FRAME_IRQ_EN to build the sticky frame interrupt; otherwise frame_irq is tied low.
module apu_frame_sequencer #(
  parameter int unsigned STEP_CYCLES = 3729
) (
  input  logic       apu_clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       irq_ack,
  output logic [7:0] p1_reg_0,
  output logic [7:0] p1_reg_1,
  output logic [7:0] p1_reg_2,
  output logic [7:0] p1_reg_3,
  output logic [7:0] p2_reg_0,
  output logic [7:0] p2_reg_1,
  output logic [7:0] p2_reg_2,
  output logic [7:0] p2_reg_3,
  output logic       qtr_clk,
  output logic       hlf_clk,
  output logic       frame_irq
);

  typedef enum logic [1:0] {IDLE, RUN, RELOAD} state_t;

  localparam logic [15:0] LAST_COUNT = 16'(STEP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [2:0]  step_q, step_d;
  logic        mode_q, mode_d;
  logic        qtr_q, qtr_d;
  logic        hlf_q, hlf_d;
  logic [7:0]  regs_q [8];
  logic [7:0]  regs_d [8];
  logic        wr_fire, ctrl_fire, wrap;

  assign wr_ready  = (state_q != RELOAD);
  assign wr_fire   = wr_valid && wr_ready;
  assign ctrl_fire = wr_fire && (wr_addr == 4'd8);
  // A control write on the wrap edge suppresses the step.
  assign wrap      = wr_ready && !ctrl_fire && (presc_q == LAST_COUNT);

  always_comb begin
    regs_d = regs_q;
    if (wr_fire && !wr_addr[3]) regs_d[wr_addr[2:0]] = wr_data;
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    step_d  = step_q;
    mode_d  = mode_q;
    qtr_d   = 1'b0;
    hlf_d   = 1'b0;
    if (state_q == RELOAD) begin
      state_d = RUN;
    end else if (ctrl_fire) begin
      state_d = RELOAD;
      presc_d = '0;
      step_d  = '0;
      mode_d  = wr_data[7];
      qtr_d   = wr_data[7];
      hlf_d   = wr_data[7];
    end else if (wrap) begin
      presc_d = '0;
      if (!mode_q) begin
        qtr_d  = 1'b1;
        hlf_d  = step_q[0];
        step_d = (step_q == 3'd3) ? 3'd0 : step_q + 3'd1;
      end else begin
        qtr_d  = (step_q != 3'd3);
        hlf_d  = (step_q == 3'd1) || (step_q == 3'd4);
        step_d = (step_q >= 3'd4) ? 3'd0 : step_q + 3'd1;
      end
    end else begin
      presc_d = presc_q + 16'd1;
    end
  end

  always_ff @(posedge apu_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      step_q  <= '0;
      mode_q  <= 1'b0;
      qtr_q   <= 1'b0;
      hlf_q   <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
      qtr_q   <= qtr_d;
      hlf_q   <= hlf_d;
      regs_q  <= regs_d;
    end
  end

`ifdef APU_FRAME_IRQ_EN
  logic inhibit_q, inhibit_d;
  logic irq_q, irq_d;

  // Set beats acknowledge, so the set is applied last.
  always_comb begin
    inhibit_d = inhibit_q;
    irq_d     = irq_q;
    if (irq_ack) irq_d = 1'b0;
    if (ctrl_fire) begin
      inhibit_d = wr_data[6];
      if (wr_data[6]) irq_d = 1'b0;
    end
    if (wrap && !mode_q && (step_q == 3'd3) && !inhibit_q) irq_d = 1'b1;
  end

  always_ff @(posedge apu_clk or posedge rst) begin
    if (rst) begin
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      inhibit_q <= inhibit_d;
      irq_q     <= irq_d;
    end
  end

  assign frame_irq = irq_q;
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack;
  assign frame_irq      = 1'b0;
`endif

  assign qtr_clk  = qtr_q;
  assign hlf_clk  = hlf_q;
  assign p1_reg_0 = regs_q[0];
  assign p1_reg_1 = regs_q[1];
  assign p1_reg_2 = regs_q[2];
  assign p1_reg_3 = regs_q[3];
  assign p2_reg_0 = regs_q[4];
  assign p2_reg_1 = regs_q[5];
  assign p2_reg_2 = regs_q[6];
  assign p2_reg_3 = regs_q[7];

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed testbench for apu_frame_sequencer with STEP_CYCLES = 4.
// Expected strobe/IRQ timings are hand-derived cycle counts from prescaler restart.
module tb_apu_frame_sequencer;

   localparam int STEP = 4;

   logic       apuClk = 1'b0;
   logic       rst;
   logic       wrValid;
   logic       wrReady;
   logic [3:0] wrAddr;
   logic [7:0] wrData;
   logic       irqAck;
   logic [7:0] p1Reg0, p1Reg1, p1Reg2, p1Reg3;
   logic [7:0] p2Reg0, p2Reg1, p2Reg2, p2Reg3;
   logic       qtrClk, hlfClk, frameIrq;

   logic [7:0] regOut [8];
   logic [7:0] expRegs [8];

   int compareCount = 0;
   int mismatchCount = 0;
   int qtrSeen;
   int hlfSeen;

   apu_frame_sequencer #(.STEP_CYCLES(STEP)) dut (
      .apu_clk  (apuClk),
      .rst      (rst),
      .wr_valid (wrValid),
      .wr_ready (wrReady),
      .wr_addr  (wrAddr),
      .wr_data  (wrData),
      .irq_ack  (irqAck),
      .p1_reg_0 (p1Reg0),
      .p1_reg_1 (p1Reg1),
      .p1_reg_2 (p1Reg2),
      .p1_reg_3 (p1Reg3),
      .p2_reg_0 (p2Reg0),
      .p2_reg_1 (p2Reg1),
      .p2_reg_2 (p2Reg2),
      .p2_reg_3 (p2Reg3),
      .qtr_clk  (qtrClk),
      .hlf_clk  (hlfClk),
      .frame_irq(frameIrq)
   );

   // Free-running 10 ns clock.
   always #5 apuClk = ~apuClk;

   // Gather the eight register outputs so they can be checked in a loop.
   assign regOut[0] = p1Reg0;
   assign regOut[1] = p1Reg1;
   assign regOut[2] = p1Reg2;
   assign regOut[3] = p1Reg3;
   assign regOut[4] = p2Reg0;
   assign regOut[5] = p2Reg1;
   assign regOut[6] = p2Reg2;
   assign regOut[7] = p2Reg3;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 ns after the rising edge.
   task automatic stepCycle();
      @(posedge apuClk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [3:0] addr, input logic [7:0] data);
      wrValid = valid;
      wrAddr  = addr;
      wrData  = data;
   endtask

   // Reset across one edge; prescaler is 0 right after release.
   task automatic applyReset();
      rst    = 1'b1;
      irqAck = 1'b0;
      applyStimulus(1'b0, 4'd0, 8'h00);
      stepCycle();
      rst = 1'b0;
   endtask

   task automatic checkRegs(input string tag);
      for (int i = 0; i < 8; i++)
         checkOutput($sformatf("%s reg%0d", tag, i), 32'(regOut[i]), 32'(expRegs[i]));
   endtask

   initial begin
      // Reset values and a single register write.
      applyReset();
      for (int i = 0; i < 8; i++) expRegs[i] = 8'h00;
      checkRegs("reset");
      checkOutput("reset qtr", 32'(qtrClk), 32'd0);
      checkOutput("reset hlf", 32'(hlfClk), 32'd0);
      checkOutput("reset irq", 32'(frameIrq), 32'd0);
      checkOutput("reset ready", 32'(wrReady), 32'd1);
      applyStimulus(1'b1, 4'd5, 8'hA7);
      stepCycle();
      applyStimulus(1'b0, 4'd0, 8'h00);
      expRegs[5] = 8'hA7;
      checkRegs("wr addr5");

      // Free-running 4-step mode: qtr every 4 cycles, hlf every 8, IRQ at step 3.
      applyReset();
      qtrSeen = 0;
      hlfSeen = 0;
      for (int k = 1; k <= 32; k++) begin
         stepCycle();
         qtrSeen += int'(qtrClk);
         hlfSeen += int'(hlfClk);
         checkOutput($sformatf("free qtr k=%0d", k), 32'(qtrClk), 32'((k % 4) == 0));
         checkOutput($sformatf("free hlf k=%0d", k), 32'(hlfClk), 32'((k % 8) == 0));
`ifdef APU_FRAME_IRQ_EN
         checkOutput($sformatf("free irq k=%0d", k), 32'(frameIrq), 32'(k >= 16));
`else
         checkOutput($sformatf("free irq k=%0d", k), 32'(frameIrq), 32'd0);
`endif
      end
      checkOutput("free qtr count", 32'(qtrSeen), 32'd8);
      checkOutput("free hlf count", 32'(hlfSeen), 32'd4);

      // 5-step control write: RELOAD pulses both strobes, then q, q+h, q, none, q+h.
      applyReset();
      applyStimulus(1'b1, 4'd8, 8'h80);
      stepCycle();
      checkOutput("reload ready", 32'(wrReady), 32'd0);
      checkOutput("reload qtr", 32'(qtrClk), 32'd1);
      checkOutput("reload hlf", 32'(hlfClk), 32'd1);
      applyStimulus(1'b1, 4'd0, 8'h55);
      for (int j = 1; j <= 21; j++) begin
         stepCycle();
         if (j == 1) begin
            applyStimulus(1'b0, 4'd0, 8'h00);
            checkOutput("reload blocks write", 32'(p1Reg0), 32'h00);
            checkOutput("post reload ready", 32'(wrReady), 32'd1);
         end
         checkOutput($sformatf("5step qtr j=%0d", j), 32'(qtrClk),
                     32'(j == 5 || j == 9 || j == 13 || j == 21));
         checkOutput($sformatf("5step hlf j=%0d", j), 32'(hlfClk), 32'(j == 9 || j == 21));
      end

      // Control write on the wrap edge: step suppressed, next strobe 4 cycles after RELOAD.
      applyReset();
      repeat (3) stepCycle();
      applyStimulus(1'b1, 4'd8, 8'h00);
      stepCycle();
      applyStimulus(1'b0, 4'd0, 8'h00);
      checkOutput("wrap-write ready", 32'(wrReady), 32'd0);
      checkOutput("wrap-write qtr", 32'(qtrClk), 32'd0);
      checkOutput("wrap-write hlf", 32'(hlfClk), 32'd0);
      for (int j = 1; j <= 5; j++) begin
         stepCycle();
         checkOutput($sformatf("after wrap qtr j=%0d", j), 32'(qtrClk), 32'(j == 5));
         checkOutput($sformatf("after wrap hlf j=%0d", j), 32'(hlfClk), 32'd0);
      end

`ifdef APU_FRAME_IRQ_EN
      // IRQ acknowledge, set-beats-ack, and clear-by-inhibit.
      applyReset();
      repeat (16) stepCycle();
      checkOutput("irq set", 32'(frameIrq), 32'd1);
      irqAck = 1'b1;
      stepCycle();
      irqAck = 1'b0;
      checkOutput("irq ack clear", 32'(frameIrq), 32'd0);
      repeat (14) stepCycle();
      irqAck = 1'b1;
      stepCycle();
      irqAck = 1'b0;
      checkOutput("irq set wins", 32'(frameIrq), 32'd1);
      checkOutput("step3 hlf", 32'(hlfClk), 32'd1);
      applyStimulus(1'b1, 4'd8, 8'h40);
      stepCycle();
      applyStimulus(1'b0, 4'd0, 8'h00);
      checkOutput("inhibit clear", 32'(frameIrq), 32'd0);
      for (int j = 1; j <= 40; j++) begin
         stepCycle();
         checkOutput($sformatf("inhibit hold j=%0d", j), 32'(frameIrq), 32'd0);
      end
`endif

      // Async reset mid-operation with registers loaded, then restart timing.
      applyReset();
      for (int i = 0; i < 8; i++) expRegs[i] = 8'h00;
      applyStimulus(1'b1, 4'd2, 8'h3C);
      stepCycle();
      applyStimulus(1'b1, 4'd9, 8'hFF);
      stepCycle();
      applyStimulus(1'b0, 4'd0, 8'h00);
      expRegs[2] = 8'h3C;
      checkRegs("addr9 ignored");
      checkOutput("addr9 no reload", 32'(wrReady), 32'd1);
      repeat (2) stepCycle();
      checkOutput("pre-reset qtr", 32'(qtrClk), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) expRegs[i] = 8'h00;
      checkRegs("async reset");
      checkOutput("async reset qtr", 32'(qtrClk), 32'd0);
      checkOutput("async reset ready", 32'(wrReady), 32'd1);
      stepCycle();
      rst = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         stepCycle();
         checkOutput($sformatf("post reset qtr j=%0d", j), 32'(qtrClk), 32'(j == 4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
